// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, flag bit positions and the ALU op
// encodings used by the ALU, the controller and the writeback stage.
package cpu_pkg;

   localparam int DATA_W = 8;

   // Flag vector layout {Z,C,V,S}; FLAG_W is the width of the packed vector.
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_S = 0;
   localparam int FLAG_W = 4;

   typedef enum logic [1:0] {
      ALU_PASS = 2'd0,
      ALU_ADD  = 2'd1,
      ALU_SUB  = 2'd2
   } alu_op_e;

   typedef logic [FLAG_W-1:0] flags_t;

   // Place the individual ALU flag outputs at their fixed bit positions.
   function automatic flags_t pack_flags(input logic z, input logic c,
                                         input logic v, input logic s);
      flags_t f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      f[FLAG_S] = s;
      return f;
   endfunction

endpackage

// File: rtl/regfile_nx8.sv
// Register file: NREGS x DATA_W, one synchronous write port, two combinational
// read ports, synchronous active-low clear. Out-of-range addresses (only
// possible for non-power-of-two NREGS) drop writes and read as zero.
module regfile_nx8 #(
   parameter  int NREGS  = 4,
   parameter  int DATA_W = 8,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra_a,
   output logic [DATA_W-1:0] rd_a,
   input  logic [ADDR_W-1:0] ra_b,
   output logic [DATA_W-1:0] rd_b
);

   localparam bit FULL = ((1 << ADDR_W) == NREGS);

   logic [DATA_W-1:0] regs [NREGS];
   logic              wr_ok;
   logic              a_ok;
   logic              b_ok;

   // Range guards only exist when the address space is not fully populated.
   if (FULL) begin : g_full
      assign wr_ok = 1'b1;
      assign a_ok  = 1'b1;
      assign b_ok  = 1'b1;
   end else begin : g_part
      assign wr_ok = (int'(wa)   < NREGS);
      assign a_ok  = (int'(ra_a) < NREGS);
      assign b_ok  = (int'(ra_b) < NREGS);
   end

   // Storage update: clear on reset, otherwise single write port.
   // NOTE: this array is reset on purpose (architectural all-zero state after
   // reset); memories without that requirement should not be reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && wr_ok) begin
         regs[wa] <= wd;
      end
   end

   assign rd_a = a_ok ? regs[ra_a] : '0;
   assign rd_b = b_ok ? regs[ra_b] : '0;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry staging register behind a valid/ready
// handshake, commit into regfile_nx8 and the flags register, commit counter.
// Optional feature macro: WB_BYPASS_EN forwards the staged result and flags
// to the read ports and flags output before they are committed.
module alu_writeback #(
   parameter  int DATA_W = cpu_pkg::DATA_W,
   parameter  int NREGS  = 4,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic [ADDR_W-1:0]         in_dst,
   input  logic                      in_wr_flags,
   input  logic                      in_zero,
   input  logic                      in_carry,
   input  logic                      in_overflow,
   input  logic                      in_sign,
   input  logic                      freeze,
   input  logic [ADDR_W-1:0]         rd_a_addr,
   input  logic [ADDR_W-1:0]         rd_b_addr,
   output logic [DATA_W-1:0]         rd_a_data,
   output logic [DATA_W-1:0]         rd_b_data,
   output logic [cpu_pkg::FLAG_W-1:0] flags,
   output logic [7:0]                commit_count
);

   import cpu_pkg::*;

   logic              stg_valid;
   logic [DATA_W-1:0] stg_data;
   logic [ADDR_W-1:0] stg_dst;
   logic              stg_wf;
   flags_t            stg_flags;
   flags_t            flags_q;

   logic              accept;
   logic              commit;
   logic [DATA_W-1:0] arr_a;
   logic [DATA_W-1:0] arr_b;

   // The stage can drain and refill on the same edge, so a full stage only
   // blocks input while frozen.
   assign in_ready = rst_n && (!stg_valid || !freeze);
   assign accept   = in_valid && in_ready;
   assign commit   = stg_valid && !freeze;

   // Staging register, committed flags and commit counter.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stg_valid    <= 1'b0;
         stg_data     <= '0;
         stg_dst      <= '0;
         stg_wf       <= 1'b0;
         stg_flags    <= '0;
         flags_q      <= '0;
         commit_count <= '0;
      end else begin
         if (accept) begin
            stg_valid <= 1'b1;
            stg_data  <= in_data;
            stg_dst   <= in_dst;
            stg_wf    <= in_wr_flags;
            stg_flags <= pack_flags(in_zero, in_carry, in_overflow, in_sign);
         end else if (commit) begin
            stg_valid <= 1'b0;
         end
         if (commit) begin
            commit_count <= commit_count + 8'd1;
            if (stg_wf) flags_q <= stg_flags;
         end
      end
   end

   regfile_nx8 #(
      .NREGS  (NREGS),
      .DATA_W (DATA_W)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (commit),
      .wa    (stg_dst),
      .wd    (stg_data),
      .ra_a  (rd_a_addr),
      .rd_a  (arr_a),
      .ra_b  (rd_b_addr),
      .rd_b  (arr_b)
   );

`ifdef WB_BYPASS_EN
   // Forward the staged entry; it is newer than anything in the array.
   // NOTE: every output of this always_comb gets a default first so no
   // latch can be inferred on any path.
   always_comb begin
      rd_a_data = arr_a;
      rd_b_data = arr_b;
      flags     = flags_q;
      if (stg_valid && (rd_a_addr == stg_dst)) rd_a_data = stg_data;
      if (stg_valid && (rd_b_addr == stg_dst)) rd_b_data = stg_data;
      if (stg_valid && stg_wf)                 flags     = stg_flags;
   end
`else
   assign rd_a_data = arr_a;
   assign rd_b_data = arr_b;
   assign flags     = flags_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed steps, a scoreboard queue
// of accepted entries that is popped on each expected commit, and a small
// architectural model of the register file, flags and commit counter.
module tb_alu_writeback;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [1:0] in_dst;
   logic       in_wr_flags;
   logic       in_zero, in_carry, in_overflow, in_sign;
   logic       freeze;
   logic [1:0] rd_a_addr, rd_b_addr;
   logic [7:0] rd_a_data, rd_b_data;
   logic [3:0] flags;
   logic [7:0] commit_count;

   alu_writeback dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_dst       (in_dst),
      .in_wr_flags  (in_wr_flags),
      .in_zero      (in_zero),
      .in_carry     (in_carry),
      .in_overflow  (in_overflow),
      .in_sign      (in_sign),
      .freeze       (freeze),
      .rd_a_addr    (rd_a_addr),
      .rd_b_addr    (rd_b_addr),
      .rd_a_data    (rd_a_data),
      .rd_b_data    (rd_b_data),
      .flags        (flags),
      .commit_count (commit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] dst;
      logic [7:0] data;
      logic       wf;
      logic [3:0] flg;
   } wb_t;

   wb_t        sb[$];
   logic [7:0] m_regs [4];
   logic [3:0] m_flags;
   logic [7:0] m_count;
   int         n_checks = 0;
   int         n_err    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // While an entry is staged (queue front), bypass builds see it early.
   function automatic logic [7:0] exp_read(input int idx);
      if (BYP && sb.size() > 0 && int'(sb[0].dst) == idx) return sb[0].data;
      return m_regs[idx];
   endfunction

   function automatic logic [3:0] exp_flags();
      if (BYP && sb.size() > 0 && sb[0].wf) return sb[0].flg;
      return m_flags;
   endfunction

   task automatic reset_model();
      sb.delete();
      for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
      m_flags = 4'd0;
      m_count = 8'd0;
   endtask

   task automatic check_reg(input int idx);
      int nxt;
      nxt       = (idx + 1) % 4;
      rd_a_addr = idx[1:0];
      rd_b_addr = nxt[1:0];
      #1;
      check($sformatf("rd_a[%0d]", idx), rd_a_data, exp_read(idx));
      check($sformatf("rd_b[%0d]", nxt), rd_b_data, exp_read(nxt));
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 4; i += 2) begin
         rd_a_addr = i[1:0];
         rd_b_addr = 2'(i + 1);
         #1;
         check({tag, "_rd_a"}, rd_a_data, 8'd0);
         check({tag, "_rd_b"}, rd_b_data, 8'd0);
      end
      check({tag, "_flags"}, flags, 4'd0);
      check({tag, "_count"}, commit_count, 8'd0);
   endtask

   // Present an entry (expected to be accepted at the next edge).
   task automatic drive(input logic [7:0] d, input logic [1:0] dst,
                        input logic wf, input logic [3:0] flg);
      wb_t it;
      in_valid    = 1'b1;
      in_data     = d;
      in_dst      = dst;
      in_wr_flags = wf;
      {in_zero, in_carry, in_overflow, in_sign} = flg;
      #1;
      check("in_ready_on_drive", in_ready, 1'b1);
      it.dst = dst; it.data = d; it.wf = wf; it.flg = flg;
      sb.push_back(it);
   endtask

   // The oldest accepted entry should have been committed at the last edge.
   task automatic expect_commit();
      wb_t it;
      check("sb_empty_at_commit", (sb.size() == 0), 1'b0);
      if (sb.size() == 0) return;
      it = sb.pop_front();
      m_regs[it.dst] = it.data;
      if (it.wf) m_flags = it.flg;
      m_count = m_count + 8'd1;
      check_reg(int'(it.dst));
      check("flags", flags, exp_flags());
      check("commit_count", commit_count, m_count);
   endtask

   initial begin
      reset_model();
      rst_n       = 1'b0;
      in_valid    = 1'b1;
      in_data     = 8'hAA;
      in_dst      = 2'd1;
      in_wr_flags = 1'b1;
      {in_zero, in_carry, in_overflow, in_sign} = 4'b1111;
      freeze      = 1'b0;
      rd_a_addr   = 2'd0;
      rd_b_addr   = 2'd0;

      // Reset with a valid input present: nothing accepted, all state zero.
      tick();
      tick();
      check("rst_in_ready", in_ready, 1'b0);
      check_all_zero("rst");
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1'b1);
      tick();
      check_all_zero("post_rst");

      // Basic: 3 -> r1 with flags written as 0000.
      drive(8'd3, 2'd1, 1'b1, 4'b0000);
      tick();
      in_valid = 1'b0;
      check_reg(1);
      check("basic_count_pre", commit_count, 8'd0);
      tick();
      expect_commit();

      // 100-100: result 0, Z=1, C=1 (no borrow), V=0, S=0 -> r2, flags written.
      drive(8'd0, 2'd2, 1'b1, 4'b1100);
      tick();
      in_valid = 1'b0;
      tick();
      expect_commit();
      check("flags_z", flags[3], 1'b1);
      // 1+2=3 -> r2 without flag write: flags keep 1100.
      drive(8'd3, 2'd2, 1'b0, 4'b0000);
      tick();
      in_valid = 1'b0;
      tick();
      expect_commit();
      check("flags_kept", flags, 4'b1100);

      // Freeze: an empty stage takes one entry, then holds it.
      freeze = 1'b1;
      drive(8'd42, 2'd3, 1'b1, 4'b0001);
      tick();
      in_data     = 8'd99;
      in_dst      = 2'd0;
      in_wr_flags = 1'b0;
      {in_zero, in_carry, in_overflow, in_sign} = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         check("frz_in_ready", in_ready, 1'b0);
         check_reg(3);
         check("frz_flags", flags, exp_flags());
         check("frz_count", commit_count, 8'd3);
         tick();
      end
      // Release: commit 42 and accept 99 on the same edge.
      freeze = 1'b0;
      drive(8'd99, 2'd0, 1'b0, 4'b0000);
      tick();
      expect_commit();
      in_valid = 1'b0;
      tick();
      expect_commit();

      // Same-destination stream 7, 135, 170 -> r0.
      drive(8'd7, 2'd0, 1'b0, 4'b0000);
      tick();
      drive(8'd135, 2'd0, 1'b0, 4'b0000);
      tick();
      expect_commit();
      drive(8'd170, 2'd0, 1'b0, 4'b0000);
      tick();
      expect_commit();
      in_valid = 1'b0;
      tick();
      expect_commit();
      check("stream_final_r0", rd_a_data, 8'd170);

      // 256 streamed commits: counter crosses 255 -> 0 and returns to start.
      for (int i = 0; i < 256; i++) begin
         drive(i[7:0], i[1:0], 1'b0, 4'b0000);
         tick();
         if (i > 0) expect_commit();
      end
      in_valid = 1'b0;
      tick();
      expect_commit();
      check("wrap_count", commit_count, 8'd8);

      // Mid-reset with an entry staged: it must never reach the array.
      freeze = 1'b1;
      drive(8'h5A, 2'd1, 1'b1, 4'b1010);
      tick();
      in_valid = 1'b0;
      check_reg(1);
      rst_n = 1'b0;
      tick();
      reset_model();
      check("midrst_in_ready", in_ready, 1'b0);
      check_all_zero("midrst");
      rst_n  = 1'b1;
      freeze = 1'b0;
      tick();
      tick();
      check_all_zero("after_midrst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback and operand-storage stage that sits directly downstream of the 8-bit ALU. It accepts each ALU result together with its zero/carry/overflow/sign flags over a valid/ready handshake and holds it in a one-entry staging register. It then commits the result to a small register file and, when requested, to the flags register. The register file's two combinational read ports drive the ALU's `a`/`b` operands, closing the datapath loop.

## Interface
- `DATA_W`, 8: data width; must match the ALU width.
- `NREGS`, 4: register-file depth; `ADDR_W = $clog2(NREGS)`.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: ALU result present.
- `in_ready`  out  1: stage can accept this cycle.
- `in_data`  in  DATA_W: ALU `result`.
- `in_dst`  in  ADDR_W: destination register index.
- `in_wr_flags`  in  1: update the flags register on commit.
- `in_zero`, `in_carry`, `in_overflow`, `in_sign`  in  1 each: ALU flag outputs.
- `freeze`  in  1: control holds commit; the staged entry stays put.
- `rd_a_addr`, `rd_b_addr`  in  ADDR_W: read-port addresses.
- `rd_a_data`, `rd_b_data`  out  DATA_W: read data, feeds ALU `a`/`b`.
- `flags`  out  4: committed flags, packed as {Z,C,V,S}, bit 3 = Z.
- `commit_count`  out  8: number of commits, wraps modulo 256.

## Operation
- Stage state: `stg_valid`, `stg_data`, `stg_dst`, `stg_wf`, `stg_flags`.
- Accept: occurs when `in_valid && in_ready`; captures all `in_*` fields into the stage.
- `in_ready = rst_n && (!stg_valid || !freeze)`. The stage drains and refills in the same cycle, giving one result per cycle.
- Commit: occurs when `stg_valid && !freeze`.
  - Writes `stg_data` to `regs[stg_dst]`.
  - If `stg_wf`, writes `stg_flags` to `flags`.
  - Increments `commit_count`.
  - Clears `stg_valid` unless a new accept happens in the same cycle.
- Without `in_wr_flags`, `flags` is unchanged on commit. Flags are never partially updated.
- Commits occur in acceptance order. Back-to-back writes to the same index leave the later value.
- Reads are combinational from the array, plus the optional bypass (see Configuration).
- Address values `>= NREGS` (non-power-of-two `NREGS` only): write is dropped, read returns 0.

## Timing
- Reset (cycle with `rst_n` low at the edge):
  - All registers = 0, `flags = 4'b0000`, `commit_count = 0`, `stg_valid = 0`.
  - `in_ready = 0` while `rst_n` is low.
  - A staged, uncommitted entry is discarded and never committed.
- Latency: accept at edge N, commit at edge N+1 if `freeze` is low at N+1.
  - Without bypass, `rd_*_data` shows the value after edge N+1.
- `freeze` held high: the stage holds indefinitely.
  - If `stg_valid`, `in_ready = 0`.
  - If empty, one accept is allowed and then `in_ready` drops.
- `freeze` falling: commit on the next edge. A new accept can happen on that same edge.
- Simultaneous commit and accept to the same `dst`: the array gets the committed value; the stage holds the newer value.
- `commit_count` 255 → 0 on the next commit; no saturation.

## Configuration
- `WB_BYPASS_EN` defined:
  - If `stg_valid` and `rd_x_addr == stg_dst`, `rd_x_data = stg_data`.
  - `flags` output shows `stg_flags` when `stg_valid && stg_wf`.
  - Effective read-after-write latency drops to 0 cycles after the accept edge.
  - The staged value wins over the array for the same index.
- Not defined:
  - Reads and `flags` reflect committed state only.
  - No comparators or bypass muxes are synthesized.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W`.
  - Flag bit indices `FLAG_Z=3`, `FLAG_C=2`, `FLAG_V=1`, `FLAG_S=0`, and `FLAG_W=4`.
  - The ALU op encodings (passthrough 0, add 1, sub 2), shared with the ALU and the controller.
- One sub-module, `regfile_nx8`: the storage array with 1 synchronous write port, 2 combinational read ports, and synchronous active-low clear.
- Staging, handshake, bypass and counter logic live in `alu_writeback`.

## Test plan
- Reset: drive `rst_n=0` for 2 cycles with `in_valid=1`.
  - `in_ready=0`; all reads 0; `flags=0000`; `commit_count=0`.
  - Release; `in_ready=1` on the next cycle.
- Basic: accept `in_data=8'd3`, `dst=1`, `in_wr_flags=1`, flags {0,0,0,0}, then `freeze=0`.
  - `rd_a_addr=1` reads 3 one edge after the accept (0 edges with bypass).
  - `commit_count=1`.
- Flags: ALU 100−100 gives result 0 with Z=1, C per the ALU; accept to `dst=2` with `in_wr_flags=1` → `flags[3]=1`.
  - Next, accept 1+2=3 to `dst=2` with `in_wr_flags=0` → `flags` unchanged, `regs[2]=3`.
- Freeze: stage 8'd42 to `dst=3`, hold `freeze=1` for 5 cycles.
  - `in_ready=0`; `regs[3]` unchanged; `commit_count` stalls.
  - Drop `freeze` → commit on the next edge, and a simultaneous new accept succeeds.
- Same-destination stream: send 7, 135, 170 to `dst=0` on back-to-back cycles → `regs[0]` ends at 170 after three commits in order.
  - With `WB_BYPASS_EN`, a read of index 0 tracks each value one edge earlier.
- Wrap and mid-reset:
  - 256 commits return `commit_count` to 0.
  - Asserting `rst_n=0` with an entry staged leaves the array at all-zero and the entry uncommitted.
